// File: rtl/ttl74x869.sv
`default_nettype none
// ============================================================================
// Module   : ttl74x869
// Brief    : WIDTH-bit synchronous up/down counter, clear/load, cascadable RCO_n
// Revision : 1.0 - initial release
// ============================================================================
module ttl74x869 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP_n,
  input  logic             ENT_n,
  output logic [WIDTH-1:0] Q,
  output logic             RCO_n
);

  localparam logic [1:0]       c_S_CLEAR = 2'b00;
  localparam logic [1:0]       c_S_DOWN  = 2'b01;
  localparam logic [1:0]       c_S_UP    = 2'b10;
  localparam logic [1:0]       c_S_LOAD  = 2'b11;
  localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             w_count_en;
  logic             w_up_tc;
  logic             w_dn_tc;

  assign w_count_en = ~ENP_n & ~ENT_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      case (S)
        c_S_CLEAR: r_q <= '0;
        c_S_LOAD:  r_q <= D;
        c_S_UP:    if (w_count_en) r_q <= r_q + c_ONE;
        c_S_DOWN:  if (w_count_en) r_q <= r_q - c_ONE;
        default:   r_q <= r_q;
      endcase
    end
  end

  // Terminal count ignores ENP_n so a cascade can chain RCO_n into the next ENT_n.
  assign w_up_tc = (S == c_S_UP)   && (r_q == c_ONES);
  assign w_dn_tc = (S == c_S_DOWN) && (r_q == '0);
  assign RCO_n   = ~(~ENT_n & (w_up_tc | w_dn_tc));

  assign Q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_ttl74x869.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttl74x869
// Brief    : scoreboard bench for ttl74x869 incl. 2x4-bit cascade into a comparator
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttl74x869;

  typedef struct packed {
    logic [7:0] q;
    logic       rco_n;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] S = 2'b00;
  logic [7:0] D = 8'h00;
  logic       ENP_n = 1'b1;
  logic       ENT_n = 1'b1;
  logic [7:0] Q;
  logic       RCO_n;

  // Cascade: two 4-bit stages, low RCO_n feeds high ENT_n.
  logic [1:0] c_S = 2'b00;
  logic       c_ENP_n = 1'b1;
  logic       c_ENT_n = 1'b1;
  logic [3:0] c_q_lo, c_q_hi;
  logic       c_rco_lo, c_rco_hi;
  logic       cmp_G_n = 1'b0;
  logic [7:0] cmp_Q = 8'h13;
  logic       cmp_P_n;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  always #5 CLK = ~CLK;

  ttl74x869 #(.WIDTH(8)) u_dut (
    .CLK(CLK), .RST(RST), .S(S), .D(D), .ENP_n(ENP_n), .ENT_n(ENT_n),
    .Q(Q), .RCO_n(RCO_n)
  );

  ttl74x869 #(.WIDTH(4)) u_lo (
    .CLK(CLK), .RST(RST), .S(c_S), .D(4'h0), .ENP_n(c_ENP_n), .ENT_n(c_ENT_n),
    .Q(c_q_lo), .RCO_n(c_rco_lo)
  );

  ttl74x869 #(.WIDTH(4)) u_hi (
    .CLK(CLK), .RST(RST), .S(c_S), .D(4'h0), .ENP_n(c_ENP_n), .ENT_n(c_rco_lo),
    .Q(c_q_hi), .RCO_n(c_rco_hi)
  );

  // Behavioural stand-in for the downstream 74x521 identity comparator.
  assign cmp_P_n = ~(~cmp_G_n & ({c_q_hi, c_q_lo} == cmp_Q));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    S = 2'b10; ENP_n = 1'b0; ENT_n = 1'b0; RST = 1'b1;
    sb.push_back('{q: 8'h00, rco_n: 1'b1});
    tick(); tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL reset_state: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    S = 2'b01; #1;
    sb.push_back('{q: 8'h00, rco_n: 1'b0});
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL reset_down_rco: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    S = 2'b10; RST = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back('{q: 8'(i), rco_n: 1'b1});
      tick();
      e = sb.pop_front(); total++;
      if (Q !== e.q || RCO_n !== e.rco_n)
        $display("FAIL reset_count%0d: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", i, Q, RCO_n, e.q, e.rco_n);
      else passed++;
    end
    RST = 1'b1;
    sb.push_back('{q: 8'h00, rco_n: 1'b1});
    tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL reset_midcount: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    RST = 1'b0;
    sb.push_back('{q: 8'h01, rco_n: 1'b1});
    tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL reset_resume: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
  endtask

  task automatic test_up_wrap();
    exp_t seq[4];
    seq[0] = '{q: 8'hFD, rco_n: 1'b1};
    seq[1] = '{q: 8'hFE, rco_n: 1'b1};
    seq[2] = '{q: 8'hFF, rco_n: 1'b0};
    seq[3] = '{q: 8'h00, rco_n: 1'b1};
    S = 2'b11; D = 8'hFD;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(seq[i]);
      tick();
      if (i == 0) begin S = 2'b10; #1; end
      e = sb.pop_front(); total++;
      if (Q !== e.q || RCO_n !== e.rco_n)
        $display("FAIL up_wrap%0d: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", i, Q, RCO_n, e.q, e.rco_n);
      else passed++;
    end
  endtask

  task automatic test_down_wrap();
    exp_t seq[4];
    seq[0] = '{q: 8'h02, rco_n: 1'b1};
    seq[1] = '{q: 8'h01, rco_n: 1'b1};
    seq[2] = '{q: 8'h00, rco_n: 1'b0};
    seq[3] = '{q: 8'hFF, rco_n: 1'b1};
    S = 2'b11; D = 8'h02;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(seq[i]);
      tick();
      if (i == 0) begin S = 2'b01; #1; end
      e = sb.pop_front(); total++;
      if (Q !== e.q || RCO_n !== e.rco_n)
        $display("FAIL down_wrap%0d: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", i, Q, RCO_n, e.q, e.rco_n);
      else passed++;
    end
  endtask

  task automatic test_enable_gating();
    // Starts at Q=FF in down mode; flipping to up re-evaluates RCO_n at once.
    ENP_n = 1'b1; ENT_n = 1'b0; S = 2'b10; #1;
    sb.push_back('{q: 8'hFF, rco_n: 1'b0});
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL dir_switch_rco: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    sb.push_back('{q: 8'hFF, rco_n: 1'b0});
    tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL enp_hold: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    ENT_n = 1'b1;
    sb.push_back('{q: 8'hFF, rco_n: 1'b1});
    tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL ent_hold: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
    ENP_n = 1'b0;
    sb.push_back('{q: 8'hFF, rco_n: 1'b1});
    tick();
    e = sb.pop_front(); total++;
    if (Q !== e.q || RCO_n !== e.rco_n)
      $display("FAIL enp_low_ent_high_hold: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", Q, RCO_n, e.q, e.rco_n);
    else passed++;
  endtask

  task automatic test_clear_load();
    logic [1:0] modes[3];
    logic [7:0] data[3];
    exp_t       seq[3];
    modes[0] = 2'b11; data[0] = 8'h5A; seq[0] = '{q: 8'h5A, rco_n: 1'b1};
    modes[1] = 2'b00; data[1] = 8'hFF; seq[1] = '{q: 8'h00, rco_n: 1'b1};
    modes[2] = 2'b11; data[2] = 8'hA5; seq[2] = '{q: 8'hA5, rco_n: 1'b1};
    ENP_n = 1'b1; ENT_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      S = modes[i]; D = data[i];
      sb.push_back(seq[i]);
      tick();
      e = sb.pop_front(); total++;
      if (Q !== e.q || RCO_n !== e.rco_n)
        $display("FAIL clear_load%0d: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", i, Q, RCO_n, e.q, e.rco_n);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes[5];
    exp_t       seq[5];
    modes[0] = 2'b11; seq[0] = '{q: 8'h10, rco_n: 1'b1};
    modes[1] = 2'b10; seq[1] = '{q: 8'h11, rco_n: 1'b1};
    modes[2] = 2'b01; seq[2] = '{q: 8'h10, rco_n: 1'b1};
    modes[3] = 2'b00; seq[3] = '{q: 8'h00, rco_n: 1'b0};
    modes[4] = 2'b11; seq[4] = '{q: 8'h33, rco_n: 1'b1};
    ENP_n = 1'b0; ENT_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      S = modes[i];
      D = (i == 0) ? 8'h10 : 8'h33;
      sb.push_back(seq[i]);
      tick();
      // After the clear, down mode at zero exposes terminal count combinationally.
      if (i == 3) begin S = 2'b01; #1; end
      e = sb.pop_front(); total++;
      if (Q !== e.q || RCO_n !== e.rco_n)
        $display("FAIL back_to_back%0d: got Q=%h RCO_n=%b want Q=%h RCO_n=%b", i, Q, RCO_n, e.q, e.rco_n);
      else passed++;
    end
  endtask

  task automatic test_cascade();
    c_S = 2'b00;
    sb.push_back('{q: 8'h00, rco_n: 1'b1});
    tick();
    e = sb.pop_front(); total++;
    if ({c_q_hi, c_q_lo} !== e.q || cmp_P_n !== e.rco_n)
      $display("FAIL cascade_clear: got cnt=%h P_n=%b want cnt=%h P_n=%b",
               {c_q_hi, c_q_lo}, cmp_P_n, e.q, e.rco_n);
    else passed++;
    c_S = 2'b10; c_ENP_n = 1'b0; c_ENT_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      sb.push_back('{q: 8'(i), rco_n: (i == 19) ? 1'b0 : 1'b1});
      tick();
      e = sb.pop_front(); total++;
      if ({c_q_hi, c_q_lo} !== e.q || cmp_P_n !== e.rco_n)
        $display("FAIL cascade_edge%0d: got cnt=%h P_n=%b want cnt=%h P_n=%b",
                 i, {c_q_hi, c_q_lo}, cmp_P_n, e.q, e.rco_n);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_enable_gating();
    test_clear_load();
    test_back_to_back();
    test_cascade();
    total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
